// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding imem request, registered delivery with a one-entry skid.
// Define JUMP_EN to add the J-type redirect (jump / jump_index ports).

module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
`ifdef JUMP_EN
  input  logic        jump,
  input  logic [25:0] jump_index,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_increment
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        vld_q, vld_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcinc_q, pcinc_d;

  logic        redirect;
  logic [31:0] redir_raw;
  logic        out_free;

`ifdef JUMP_EN
  assign redirect  = branch_taken | jump;
  assign redir_raw = branch_taken ? branch_target : {pcinc_q[31:28], jump_index, 2'b00};
`else
  assign redirect  = branch_taken;
  assign redir_raw = branch_target;
`endif

  // output register can take a new word: empty, or being consumed this cycle
  assign out_free = !vld_q || !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      // an in-flight request must still complete, so WAIT holds until its ack
      state_d = (state_q == S_WAIT && !imem_ack) ? S_WAIT : S_FETCH;
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
        S_FETCH: if (!stall) state_d = S_WAIT;
        S_WAIT:  if (imem_ack) state_d = (kill_q || out_free) ? S_FETCH : S_FULL;
        S_FULL:  if (!stall) state_d = S_FETCH;
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    vld_d        = vld_q;
    pc_d         = pc_q;
    pcinc_d      = pcinc_q;
    if (vld_q && !stall) vld_d = 1'b0;
    if (redirect) begin
      fetch_pc_d = {redir_raw[31:2], 2'b00};
      vld_d      = 1'b0;
      skid_vld_d = 1'b0;
      if (state_q == S_WAIT) begin
        if (imem_ack) begin
          req_d  = 1'b0;
          kill_d = 1'b0;
        end else begin
          kill_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        S_FETCH: if (!stall) begin
          req_d  = 1'b1;
          addr_d = fetch_pc_q;
        end
        S_WAIT: if (imem_ack) begin
          req_d  = 1'b0;
          kill_d = 1'b0;
          if (!kill_q) begin
            fetch_pc_d = addr_q + 32'd4;
            if (out_free) begin
              instr_d = imem_rdata;
              pc_d    = addr_q;
              pcinc_d = addr_q + 32'd4;
              vld_d   = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = addr_q;
              skid_vld_d   = 1'b1;
            end
          end
        end
        S_FULL: if (!stall && skid_vld_q) begin
          instr_d    = skid_instr_q;
          pc_d       = skid_pc_q;
          pcinc_d    = skid_pc_q + 32'd4;
          vld_d      = 1'b1;
          skid_vld_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_VECTOR;
      kill_q       <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      instr_q      <= '0;
      vld_q        <= 1'b0;
      pc_q         <= '0;
      pcinc_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      vld_q        <= vld_d;
      pc_q         <= pc_d;
      pcinc_q      <= pcinc_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign instr        = instr_q;
  assign instr_valid  = vld_q;
  assign pc           = pc_q;
  assign pc_increment = pcinc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized stall/branch/ack traffic scored against
// an in-order delivery queue and next-fetch-address model.

module tb_pc_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, branch_taken, imem_ack, imem_req, instr_valid;
  logic [31:0] branch_target, imem_addr, imem_rdata, instr, pc, pc_increment;
`ifdef JUMP_EN
  logic        jump;
  logic [25:0] jump_index;
`endif

  logic        w_req, w_ack, w_vld;
  logic [31:0] w_addr, w_instr, w_pc, w_pcinc;

  pc_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
`ifdef JUMP_EN
    .jump(jump), .jump_index(jump_index),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_increment(pc_increment)
  );

  pc_fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
`ifdef JUMP_EN
    .jump(1'b0), .jump_index(26'h0),
`endif
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(32'h1234_5678),
    .instr(w_instr), .instr_valid(w_vld), .pc(w_pc), .pc_increment(w_pcinc)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] d;} ent_t;

  ent_t        q[$];
  logic [31:0] req_log[$], inc_log[$], wlog[$];
  int          ncmp = 0, nerr = 0;
  logic [31:0] nf, req_a;
  logic        outst, killed, just_acked, prev_wreq, spur, rnd_lat;
  int          cnt, ack_lat;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    nf = 32'h0; outst = 1'b0; killed = 1'b0; just_acked = 1'b0; prev_wreq = 1'b0; cnt = 0;
  endtask

  // One cycle: score outputs seen at negedge, drive inputs for the next posedge, advance model.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic jmp, input logic [25:0] jidx);
    logic        ack, redir;
    logic [31:0] rt, tmp;
    ent_t        e;
    @(negedge clk);
    chk("valid", instr_valid, q.size() != 0);
    if (just_acked) chk("req_drop", imem_req, 0);
    just_acked = 1'b0;
    if (outst) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, req_a);
    end else if (imem_req) begin
      chk("req_addr", imem_addr, nf);
      req_log.push_back(imem_addr);
      outst = 1'b1;
      req_a = nf;
      cnt   = rnd_lat ? int'($urandom_range(0, 3)) : ack_lat;
    end
    ack = 1'b0;
    if (outst) begin
      if (cnt == 0) ack = 1'b1;
      else cnt--;
    end
    if (w_req && !prev_wreq) wlog.push_back(w_addr);
    prev_wreq = w_req;
    w_ack     = w_req;
    redir = br;
    rt    = tgt & 32'hFFFF_FFFC;
    tmp   = 32'h0;
`ifdef JUMP_EN
    if (!br && jmp && q.size() != 0) begin
      tmp   = q[0].a + 32'd4;
      redir = 1'b1;
      rt    = {tmp[31:28], jidx, 2'b00};
    end
    jump       = jmp;
    jump_index = jidx;
`endif
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_ack      = ack | (spur & !outst);
    imem_rdata    = ack ? mem(req_a) : $urandom;
    if (q.size() != 0 && !st) begin
      e = q.pop_front();
      chk("pc", pc, e.a);
      chk("instr", instr, e.d);
      chk("pc_inc", pc_increment, e.a + 32'd4);
      inc_log.push_back(e.a + 32'd4);
    end
    if (ack) begin
      outst = 1'b0;
      just_acked = 1'b1;
      if (!redir && !killed) begin
        q.push_back('{req_a, mem(req_a)});
        nf = req_a + 32'd4;
      end
      killed = 1'b0;
    end
    if (redir) begin
      q.delete();
      nf = rt;
      if (outst) killed = 1'b1;
    end
  endtask

  initial begin
    int base;
    logic [31:0] held;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; w_ack = 1'b0; spur = 1'b0; rnd_lat = 1'b0; ack_lat = 1;
`ifdef JUMP_EN
    jump = 1'b0; jump_index = '0;
`endif
    model_reset();
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pcinc", pc_increment, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // in-order fetch, ack one cycle after each request
    repeat (14) step(0, 0, 0, 0, 0);
    chk("seq_len", req_log.size() >= 3 && inc_log.size() >= 3, 1);
    if (req_log.size() >= 3 && inc_log.size() >= 3) begin
      chk("seq_a0", req_log[0], 32'h0);
      chk("seq_a1", req_log[1], 32'h4);
      chk("seq_a2", req_log[2], 32'h8);
      chk("seq_i0", inc_log[0], 32'h4);
      chk("seq_i1", inc_log[1], 32'h8);
      chk("seq_i2", inc_log[2], 32'hC);
    end
    chk("wrap_len", wlog.size() >= 2, 1);
    if (wlog.size() >= 2) begin
      chk("wrap_a0", wlog[0], 32'hFFFF_FFFC);
      chk("wrap_a1", wlog[1], 32'h0);
    end

    // stall for three cycles once a word is on the output; it must hold then deliver
    for (int i = 0; i < 12 && q.size() == 0; i++) step(0, 0, 0, 0, 0);
    held = (q.size() != 0) ? q[0].a : 32'hDEAD_DEAD;
    repeat (3) step(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("stall_hold_pc", pc, held);
    repeat (10) step(0, 0, 0, 0, 0);

    // branch to an unaligned target while a request is in flight
    ack_lat = 3;
    for (int i = 0; i < 10 && !outst; i++) step(0, 0, 0, 0, 0);
    base = req_log.size();
    step(0, 1, 32'h0000_0103, 0, 0);
    repeat (12) step(0, 0, 0, 0, 0);
    chk("br_len", req_log.size() > base, 1);
    if (req_log.size() > base) chk("br_addr", req_log[base], 32'h0000_0100);

    // fetch across the top of the address space
    ack_lat = 0;
    step(0, 1, 32'hFFFF_FFF8, 0, 0);
    base = req_log.size();
    repeat (12) step(0, 0, 0, 0, 0);
    chk("top_len", req_log.size() >= base + 3, 1);
    if (req_log.size() >= base + 3) begin
      chk("top_a0", req_log[base + 1], 32'hFFFF_FFFC);
      chk("top_a1", req_log[base + 2], 32'h0);
    end

`ifdef JUMP_EN
    step(0, 1, 32'h4000_0004, 0, 0);
    for (int i = 0; i < 12 && q.size() == 0; i++) step(0, 0, 0, 0, 0);
    base = req_log.size();
    step(1, 0, 0, 1, 26'h000_0010);
    repeat (6) step(0, 0, 0, 0, 0);
    if (req_log.size() > base) chk("jmp_addr", req_log[base], 32'h4000_0040);
    for (int i = 0; i < 12 && q.size() == 0; i++) step(0, 0, 0, 0, 0);
    base = req_log.size();
    step(1, 1, 32'h0000_0080, 1, 26'h000_0010);
    repeat (6) step(0, 0, 0, 0, 0);
    if (req_log.size() > base) chk("jmp_br_addr", req_log[base], 32'h0000_0080);
`endif

    // randomized traffic
    rnd_lat = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic        st, br, jp;
      st = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 15) == 0);
      jp = ($urandom_range(0, 15) == 0) && (q.size() != 0);
      step(st, br, $urandom, jp, 26'($urandom));
    end

    // reset in the middle of a request, then a stray ack that must be ignored
    for (int i = 0; i < 10 && !outst; i++) step(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_pc", pc, 0);
    model_reset();
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; stall = 1'b0; branch_taken = 1'b0;
    rst_n = 1'b1;
    spur = 1'b1;
    step(0, 0, 0, 0, 0);
    spur = 1'b0;
    base = req_log.size();
    repeat (12) step(0, 0, 0, 0, 0);
    if (req_log.size() > base) chk("post_rst_addr", req_log[base], 32'h0);
    chk("post_rst_len", req_log.size() > base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_VECTOR, 32'h00000000, first fetch address after reset.
REQ-002 clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-005 branch_taken  input  1  redirect fetch to branch_target.
REQ-006 branch_target  input  32  branch address from the address adder.
REQ-007 jump  input  1  redirect to the J-type target; present only with JUMP_EN.
REQ-008 jump_index  input  26  J-type instr_index field; present only with JUMP_EN.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  word address of the outstanding request.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 instr  output  32  instruction delivered downstream.
REQ-014 instr_valid  output  1  instr, pc and pc_increment are valid.
REQ-015 pc  output  32  address of the delivered instruction.
REQ-016 pc_increment  output  32  pc + 4, registered.

Function
REQ-017 The FSM SHALL have states BOOT, FETCH, WAIT, FULL; BOOT SHALL go to FETCH unconditionally after one cycle.
REQ-018 In FETCH with stall=0, the block SHALL assert imem_req with imem_addr = fetch_pc and go to WAIT.
REQ-019 In FETCH with stall=1, no request SHALL be launched.
REQ-020 Once imem_req is asserted, imem_req and imem_addr SHALL stay stable until the imem_ack cycle, whatever stall does.
REQ-021 imem_req SHALL drop in the cycle after imem_ack; one request at most SHALL be outstanding.
REQ-022 On imem_ack with the output register empty or stall=0, instr/pc/pc_increment SHALL load next cycle, instr_valid=1, fetch_pc += 4, next state FETCH.
REQ-023 On imem_ack with instr_valid=1 and stall=1, the word SHALL be captured into a one-entry skid register and the FSM SHALL go to FULL.
REQ-024 In FULL, on the first cycle with stall=0, the skid entry SHALL move to the output register and the FSM SHALL go to FETCH.
REQ-025 A delivered instruction SHALL be consumed in a cycle with instr_valid=1 and stall=0; otherwise the outputs SHALL hold; instr_valid SHALL clear after consumption when no new word loads.
REQ-026 fetch_pc + 4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-027 A redirect (branch_taken, or jump with JUMP_EN) SHALL set fetch_pc to the target next cycle, clear instr_valid and the skid entry, and return to FETCH.
REQ-028 Redirect bits [1:0] SHALL be forced to 2'b00.
REQ-029 A redirect SHALL take priority over stall and over a simultaneous imem_ack.
REQ-030 branch_taken SHALL win over a simultaneous jump.
REQ-031 A redirect while in WAIT SHALL set a kill flag; the matching ack data SHALL be discarded, then the new target SHALL be fetched.

Reset
REQ-032 On rst_n=0, immediately and without clk: fetch_pc=RESET_VECTOR, state=BOOT, kill=0, skid empty, imem_req=0, imem_addr=0, instr=0, instr_valid=0, pc=0, pc_increment=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; an ack after reset release SHALL be ignored until a new request is issued.

Configuration
REQ-034 With JUMP_EN defined, jump and jump_index SHALL exist and the jump target SHALL be {pc_increment[31:28], jump_index, 2'b00}, from the delivered instruction.
REQ-035 Without JUMP_EN, the jump ports SHALL be absent and branch_taken SHALL be the only redirect.

Verification
REQ-036 Reset release, ack every request after 1 cycle, stall=0 -> imem_addr 0x0,0x4,0x8; pc_increment 0x4,0x8,0xC with instr_valid=1.
REQ-037 stall=1 for 3 cycles after first delivery, ack returns during stall -> skid fills, FULL entered, second word delivered on the cycle after stall drops, nothing lost.
REQ-038 branch_taken=1, branch_target=0x00000103 while in WAIT -> ack data discarded, next imem_addr=0x00000100, instr_valid=0 until it returns.
REQ-039 RESET_VECTOR=0xFFFFFFFC -> first fetch 0xFFFFFFFC, second 0x00000000.
REQ-040 JUMP_EN, pc_increment=0x40000008, jump_index=26'h0000010, jump=1 with branch_taken=0 -> next imem_addr=0x40000040; repeat with branch_taken=1 -> branch_target used.
